// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_pkg
// Brief    : Default geometry constants and address-width helper for the
//            RAM-backed FIFO controller.
// Revision : 1.0
// ============================================================================
package ram_fifo_pkg;

  localparam int DEF_MEM_WIDTH = 16;
  localparam int DEF_MEM_DEPTH = 1024;
  localparam int DEF_AFULL_LVL = 1000;

  function automatic int addr_size(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_ADDR_SIZE = addr_size(DEF_MEM_DEPTH);

endpackage
`default_nettype wire

// File: rtl/dpr_sync.sv
`default_nettype none
// ============================================================================
// Module   : dpr_sync
// Brief    : Dual-port synchronous RAM, one write port and one read port,
//            one-cycle read latency, read-before-write on address collision.
// Revision : 1.0
// ============================================================================
module dpr_sync #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blk_select,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] addr_wr,
  input  logic [MEM_WIDTH-1:0] din,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] addr_rd,
  output logic [MEM_WIDTH-1:0] dout
);

  logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (blk_select && wr_en) r_mem[addr_wr] <= din;
  end

  // Read samples the array before this edge's write lands, so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (blk_select && rd_en) begin
      r_dout <= r_mem[addr_rd];
    end
  end

  assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_ctrl
// Brief    : FIFO controller driving a dpr_sync RAM: push/pop handshake to RAM
//            commands, wrap-around pointers, occupancy and status flags.
// Revision : 1.0
// ============================================================================
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = addr_size(MEM_DEPTH),
  parameter int AFULL_LVL = DEF_AFULL_LVL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [MEM_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [MEM_WIDTH-1:0] pop_data,
  output logic                 pop_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  output logic [MEM_WIDTH-1:0] mem_din,
  output logic [ADDR_SIZE-1:0] mem_addr_wr,
  output logic [ADDR_SIZE-1:0] mem_addr_rd,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic                 mem_blk_select,
  input  logic [MEM_WIDTH-1:0] mem_dout
);

  localparam logic [ADDR_SIZE:0] c_depth = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] c_afull = (ADDR_SIZE+1)'(AFULL_LVL);

  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [ADDR_SIZE:0]   r_count;
  logic                 r_pop_valid;
  logic                 r_overflow;
  logic                 r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop_acc;
  logic w_push_acc;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push paired with a pop.
  assign w_pop_acc  = pop  & ~w_empty & ~flush;
  assign w_push_acc = push & (~w_full | w_pop_acc) & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_acc;
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (push && !w_push_acc) r_overflow  <= 1'b1;
      if (pop  && !w_pop_acc)  r_underflow <= 1'b1;
    end
  end

  assign mem_wr_en      = w_push_acc;
  assign mem_rd_en      = w_pop_acc;
  assign mem_blk_select = w_push_acc | w_pop_acc;
  assign mem_addr_wr    = r_wr_ptr;
  assign mem_addr_rd    = r_rd_ptr;
  assign mem_din        = push_data;

  assign pop_data    = mem_dout;
  assign pop_valid   = r_pop_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= c_afull);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_fifo_ctrl
// Brief    : Self-checking bench for ram_fifo_ctrl with a dpr_sync RAM behind it.
// Revision : 1.0
// ============================================================================
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int A  = 10;
  localparam int AF = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] push_data = '0;

  logic [W-1:0] pop_data, mem_din, mem_dout;
  logic         pop_valid, full, empty, almost_full, overflow, underflow;
  logic [A:0]   count;
  logic [A-1:0] mem_addr_wr, mem_addr_rd;
  logic         mem_wr_en, mem_rd_en, mem_blk_select;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] m_q [$];
  logic [W-1:0] sb_q [$];
  logic [W-1:0] exp_word;
  logic [W-1:0] last_pop = '0;
  logic [A-1:0] m_wr = '0;
  logic [A-1:0] m_rd = '0;

  ram_fifo_ctrl #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A), .AFULL_LVL(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
    .mem_din(mem_din), .mem_addr_wr(mem_addr_wr), .mem_addr_rd(mem_addr_rd),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_blk_select(mem_blk_select),
    .mem_dout(mem_dout)
  );

  dpr_sync #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A)) u_ram (
    .clk(clk), .rst(1'b0), .blk_select(mem_blk_select), .wr_en(mem_wr_en),
    .addr_wr(mem_addr_wr), .din(mem_din), .rd_en(mem_rd_en), .addr_rd(mem_addr_rd),
    .dout(mem_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every pop the model accepts must surface as pop_valid one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      if (pop_valid === 1'b1) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL pop_spurious: pop_valid=1 data=%h, required pop_valid=0", pop_data);
        end else begin
          exp_word = sb_q.pop_front();
          last_pop = pop_data;
          if (pop_data !== exp_word) $display("FAIL pop_data: got %h, required %h", pop_data, exp_word);
          else n_pass++;
        end
      end else if (sb_q.size() != 0) begin
        n_total++;
        exp_word = sb_q.pop_front();
        $display("FAIL pop_valid_missing: got %b, required 1 (data %h)", pop_valid, exp_word);
      end
    end
  end

  // Drives one cycle starting just after a rising edge and updates the reference model.
  task automatic step(input logic p, input logic [W-1:0] d, input logic q);
    logic pa, wa;
    push = p; push_data = d; pop = q;
    pa = q && !flush && (m_q.size() > 0);
    wa = p && !flush && ((m_q.size() < D) || pa);
    @(posedge clk);
    if (flush) begin
      m_q.delete();
      m_wr = '0;
      m_rd = '0;
    end
    if (pa) begin
      sb_q.push_back(m_q.pop_front());
      m_rd = m_rd + 1'b1;
    end
    if (wa) begin
      m_q.push_back(d);
      m_wr = m_wr + 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({pop_valid, full, almost_full, overflow, underflow, empty} !== 6'b000001)
      $display("FAIL reset_flags: got %b, required 000001", {pop_valid, full, almost_full, overflow, underflow, empty});
    else n_pass++;
    n_total++;
    if ({count, mem_addr_wr, mem_addr_rd} !== '0)
      $display("FAIL reset_count_ptrs: got count=%0d wr=%0d rd=%0d, required 0 0 0", count, mem_addr_wr, mem_addr_rd);
    else n_pass++;
    n_total++;
    if ({mem_wr_en, mem_rd_en, mem_blk_select} !== 3'b000)
      $display("FAIL reset_mem_en: got %b, required 000", {mem_wr_en, mem_rd_en, mem_blk_select});
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0);
      n_total++;
      if ({empty, count, mem_blk_select} !== {1'b1, 11'd0, 1'b0})
        $display("FAIL idle_state: got empty=%b count=%0d blk=%b, required 1 0 0", empty, count, mem_blk_select);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; push_data = 16'(i); pop = 1'b0;
      #1;
      n_total++;
      if ({mem_wr_en, mem_rd_en, mem_blk_select, mem_addr_wr, mem_din} !== {3'b101, m_wr, 16'(i)})
        $display("FAIL push_cmd: got en=%b addr=%0d din=%h, required 101 %0d %h",
                 {mem_wr_en, mem_rd_en, mem_blk_select}, mem_addr_wr, mem_din, m_wr, 16'(i));
      else n_pass++;
      step(1'b1, 16'(i), 1'b0);
      if (i == 1) begin
        n_total++;
        if ({empty, count} !== {1'b0, 11'd1})
          $display("FAIL write_to_read: got empty=%b count=%0d, required 0 1", empty, count);
        else n_pass++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      push = 1'b0; pop = 1'b1;
      #1;
      n_total++;
      if ({mem_rd_en, mem_wr_en, mem_addr_rd} !== {2'b10, m_rd})
        $display("FAIL pop_cmd: got rd=%b wr=%b addr=%0d, required 1 0 %0d", mem_rd_en, mem_wr_en, mem_addr_rd, m_rd);
      else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b0);
    n_total++;
    if ({empty, count} !== {1'b1, 11'd0})
      $display("FAIL basic_drained: got empty=%b count=%0d, required 1 0", empty, count);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      step(1'b1, 16'(i) ^ 16'hA5A5, 1'b0);
      n_total++;
      if ({full, almost_full, count} !== {m_q.size() == D, m_q.size() >= AF, 11'(m_q.size())})
        $display("FAIL fill_flags: got full=%b afull=%b count=%0d, required %b %b %0d",
                 full, almost_full, count, m_q.size() == D, m_q.size() >= AF, m_q.size());
      else n_pass++;
    end
    push = 1'b1; push_data = 16'hDEAD; pop = 1'b0;
    #1;
    n_total++;
    if ({mem_wr_en, mem_blk_select} !== 2'b00)
      $display("FAIL overflow_cmd: got wr=%b blk=%b, required 0 0", mem_wr_en, mem_blk_select);
    else n_pass++;
    step(1'b1, 16'hDEAD, 1'b0);
    n_total++;
    if ({overflow, full, count} !== {2'b11, 11'd1024})
      $display("FAIL overflow_flag: got ovf=%b full=%b count=%0d, required 1 1 1024", overflow, full, count);
    else n_pass++;
  endtask

  task automatic test_full_pushpop();
    push = 1'b1; push_data = 16'hBEEF; pop = 1'b1;
    #1;
    n_total++;
    if ({mem_wr_en, mem_rd_en, mem_addr_wr, mem_addr_rd} !== {2'b11, m_wr, m_rd})
      $display("FAIL full_pushpop_cmd: got wr=%b rd=%b aw=%0d ar=%0d, required 1 1 %0d %0d",
               mem_wr_en, mem_rd_en, mem_addr_wr, mem_addr_rd, m_wr, m_rd);
    else n_pass++;
    step(1'b1, 16'hBEEF, 1'b1);
    n_total++;
    if ({full, count} !== {1'b1, 11'd1024})
      $display("FAIL full_pushpop_count: got full=%b count=%0d, required 1 1024", full, count);
    else n_pass++;
    for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    n_total++;
    if ({last_pop, empty} !== {16'hBEEF, 1'b1})
      $display("FAIL drain_last: got last=%h empty=%b, required beef 1", last_pop, empty);
    else n_pass++;
  endtask

  task automatic test_underflow();
    push = 1'b0; pop = 1'b1;
    #1;
    n_total++;
    if ({mem_rd_en, mem_blk_select} !== 2'b00)
      $display("FAIL underflow_cmd: got rd=%b blk=%b, required 0 0", mem_rd_en, mem_blk_select);
    else n_pass++;
    step(1'b0, '0, 1'b1);
    n_total++;
    if ({underflow, pop_valid} !== 2'b10)
      $display("FAIL underflow_flag: got udf=%b pop_valid=%b, required 1 0", underflow, pop_valid);
    else n_pass++;
    push = 1'b1; push_data = 16'h1234; pop = 1'b1;
    #1;
    n_total++;
    if ({mem_wr_en, mem_rd_en} !== 2'b10)
      $display("FAIL empty_pushpop_cmd: got wr=%b rd=%b, required 1 0", mem_wr_en, mem_rd_en);
    else n_pass++;
    step(1'b1, 16'h1234, 1'b1);
    n_total++;
    if ({count, empty} !== {11'd1, 1'b0})
      $display("FAIL empty_pushpop_count: got count=%0d empty=%b, required 1 0", count, empty);
    else n_pass++;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap_flush();
    int pushed;
    logic p, q;
    pushed = 0;
    while (pushed < 1500) begin
      p = (m_q.size() < 8) && ($urandom_range(0, 3) != 0);
      q = ($urandom_range(0, 1) != 0);
      step(p, 16'($urandom), q);
      if (p) pushed++;
      n_total++;
      if (count !== 11'(m_q.size()))
        $display("FAIL wrap_count: got %0d, required %0d", count, m_q.size());
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
    flush = 1'b1; push = 1'b1; pop = 1'b1;
    #1;
    n_total++;
    if ({mem_wr_en, mem_rd_en, mem_blk_select} !== 3'b000)
      $display("FAIL flush_cmd: got %b, required 000", {mem_wr_en, mem_rd_en, mem_blk_select});
    else n_pass++;
    step(1'b1, 16'hFFFF, 1'b1);
    flush = 1'b0;
    n_total++;
    if ({count, empty, overflow, underflow, pop_valid, mem_addr_wr, mem_addr_rd} !== {11'd0, 4'b1000, 20'd0})
      $display("FAIL flush_state: got count=%0d empty=%b ovf=%b udf=%b pv=%b wr=%0d rd=%0d, required 0 1 0 0 0 0 0",
               count, empty, overflow, underflow, pop_valid, mem_addr_wr, mem_addr_rd);
    else n_pass++;
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h5A00 + 16'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    pop = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    n_total++;
    if ({pop_valid, mem_rd_en, mem_blk_select} !== 3'b000)
      $display("FAIL rst_midburst_pv: got pv=%b rd=%b blk=%b, required 0 0 0", pop_valid, mem_rd_en, mem_blk_select);
    else n_pass++;
    n_total++;
    if ({count, empty, full, almost_full, overflow, underflow} !== {11'd0, 5'b10000})
      $display("FAIL rst_midburst_state: got count=%0d flags=%b, required 0 10000",
               count, {empty, full, almost_full, overflow, underflow});
    else n_pass++;
    sb_q.delete();
    m_q.delete();
    m_wr = '0;
    m_rd = '0;
    pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    n_total++;
    if ({pop_valid, empty, count} !== {2'b01, 11'd0})
      $display("FAIL rst_release: got pv=%b empty=%b count=%0d, required 0 1 0", pop_valid, empty, count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_pushpop();
    test_underflow();
    test_wrap_flush();
    test_reset_midburst();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

- Synchronous FIFO controller that acts as the initiator for the team's dual-port synchronous RAM (`dpr_sync`).
- Converts a push/pop handshake into RAM write-port and read-port commands, and manages wrap-around read/write pointers and occupancy.
- Returns popped data with the RAM's one-cycle read latency, qualified by a valid strobe.
- Sits between a producer/consumer pair and one `dpr_sync` instance. The integrator ties the RAM's own `rst` low.

## Interface
- `MEM_WIDTH`, 16, data width (must match RAM).
- `MEM_DEPTH`, 1024, number of entries (power of two, must match RAM).
- `ADDR_SIZE`, 10, log2(`MEM_DEPTH`).
- `AFULL_LVL`, 1000, `almost_full` asserts when `count >= AFULL_LVL`.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous assert, active-low.
- `flush` in 1 — synchronous clear of pointers and count.
- `push` in 1 — write request.
- `push_data` in `MEM_WIDTH` — write data.
- `pop` in 1 — read request.
- `pop_data` out `MEM_WIDTH` — read data; equals `mem_dout`, valid when `pop_valid`=1.
- `pop_valid` out 1 — `pop_data` valid this cycle.
- `full`, `empty`, `almost_full` out 1 — status flags.
- `count` out `ADDR_SIZE+1` — occupancy, 0..`MEM_DEPTH`.
- `overflow`, `underflow` out 1 — sticky error flags; cleared by `rst` or `flush`.
- `mem_din` out `MEM_WIDTH` — to RAM `din`.
- `mem_addr_wr`, `mem_addr_rd` out `ADDR_SIZE` — to RAM.
- `mem_wr_en`, `mem_rd_en`, `mem_blk_select` out 1 — to RAM.
- `mem_dout` in `MEM_WIDTH` — from RAM `dout`.

## Operation
**Acceptance**
- Push is accepted when `push & (~full | pop_acc)`.
- Pop is accepted when `pop & ~empty`.
- Rejected push sets `overflow`; rejected pop sets `underflow`.

**RAM command (combinational, same cycle as the request)**
- `mem_wr_en` = push accepted; `mem_addr_wr` = `wr_ptr`; `mem_din` = `push_data`.
- `mem_rd_en` = pop accepted; `mem_addr_rd` = `rd_ptr`.
- `mem_blk_select` = `mem_wr_en | mem_rd_en`; it is 0 when the controller is idle.

**Pointers and count (registered)**
- `wr_ptr`/`rd_ptr` are `ADDR_SIZE` bits and increment on acceptance, wrapping from `MEM_DEPTH-1` to 0.
- `count` changes by +1 (push only), −1 (pop only), or 0 (both or neither).

**Flags**
- `full` = (`count`==`MEM_DEPTH`); `empty` = (`count`==0). Both are registered-derived, with no combinational path from `push`/`pop`.

**Simultaneous events**
- Empty with push+pop: pop rejected (`underflow` set), push accepted, `count` becomes 1.
- Full with push+pop: both accepted, `count` unchanged. `wr_ptr`==`rd_ptr`; the RAM returns the old entry, which is the correct popped value.
- `flush` has priority over push/pop: pointers, `count` and sticky flags go to 0, no RAM command is issued that cycle, and `pop_valid` goes to 0 next cycle.

## Timing
- Reset values:
  - `pop_valid`, `full`, `almost_full`, `overflow`, `underflow`, `count` = 0.
  - `empty` = 1.
  - All `mem_*` enables = 0.
  - Pointers = 0.
- Pop latency: pop accepted in cycle N → `pop_valid`=1 and `pop_data` valid in cycle N+1.
- Back-to-back pops give one word per cycle.
- Write-to-read: a word pushed in cycle N is poppable from cycle N+1 (`empty` deasserts in N+1). Its data appears in N+2.
- Reset asserted mid-burst: all state clears immediately. A RAM read in flight is discarded (`pop_valid` forced 0).

## Structure
- Package `ram_fifo_pkg`: default width/depth constants and the `ADDR_SIZE` derivation function (clog2).
- Single module, no sub-modules.
- The bench instantiates `ram_fifo_ctrl` plus `dpr_sync` as the reference RAM.

## Test plan
- Reset, then idle 5 cycles → `empty`=1, `count`=0, `mem_blk_select`=0 throughout.
- Push 0x0001..0x0004, then pop 4 → `pop_data` 0x0001..0x0004 on consecutive cycles, each one cycle after its pop; `empty`=1 after.
- Fill 1024 words → `full`=1 at `count`=1024. `almost_full`=1 from `count`=1000. An extra push sets `overflow` and leaves memory unchanged.
- Full, push 0xBEEF + pop same cycle → pop returns the oldest word, `count` stays 1024. After draining, 0xBEEF is last.
- Empty, pop alone → `underflow`=1, `pop_valid` stays 0. Push+pop together → `count`=1.
- Wrap: push/pop 1500 words with occupancy ≤ 8 → data order preserved across the pointer wrap. Then `flush` → `count`=0 next cycle.
- Assert `rst` low mid-pop burst → `pop_valid` drops immediately and all flags return to reset values.
